dm_arbiter: RTL

Two-port arbiter and access sequencer placed in front of the 4 KB word-addressed data memory `dm_4k`. It shares the memory's single port between the CPU data port (port 0) and the debug/DMA port (port 1). Each port sees a req/ack handshake with byte enables. Because the memory only supports whole-word writes, partial-word writes are executed as a read-modify-write sequence.

---
 rtl/dm_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port req/ack arbiter in front of dm_4k, with read-modify-write for partial-word writes.
module dm_arbiter #(
  parameter int AW = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [3:0]    be0,
  input  logic [3:0]    be1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  input  logic [31:0]   mem_dout,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;
  state_t state, state_nx;
  logic win, ptr, l_we;
  logic [AW-1:0] l_addr;
  logic [3:0] l_be;
  logic [31:0] l_wdata, din_r, merged;
  logic e0, e1, gnt, g1, full, partial, done;
  // A port still showing its ack is masked so its trailing req is not regranted.
  always_comb begin
    e0 = req0 & ~ack0;
    e1 = req1 & ~ack1;
    gnt = e0 | e1;
    g1 = e1 & (~e0 | (!FIXED_PRIO && ptr));
    full = l_be == 4'hf;
    partial = l_we && l_be != 4'h0 && !full;
    done = (state == ACCESS && !partial) || state == MERGE_WR;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = l_be[i] ? l_wdata[8*i +: 8] : mem_dout[8*i +: 8];
    state_nx = state == IDLE ? (gnt ? ACCESS : IDLE) :
               (state == ACCESS && partial) ? MERGE_WR : IDLE;
    mem_we = state == MERGE_WR || (state == ACCESS && l_we && full);
    busy = state != IDLE;
  end
  assign mem_addr = l_addr;
  assign mem_din = din_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // din_r holds wdata for full writes and is overwritten with the merged word for partial ones.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win <= 1'b0;
      ptr <= 1'b0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_be <= 4'h0;
      l_wdata <= 32'h0;
      din_r <= 32'h0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= 32'h0;
      rdata1 <= 32'h0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE && gnt) begin
        win <= g1;
        ptr <= ~g1;
        l_we <= g1 ? we1 : we0;
        l_addr <= g1 ? addr1 : addr0;
        l_be <= g1 ? be1 : be0;
        l_wdata <= g1 ? wdata1 : wdata0;
        din_r <= g1 ? wdata1 : wdata0;
      end
      if (state == ACCESS && partial) din_r <= merged;
      if (done) begin
        ack0 <= !win;
        ack1 <= win;
      end
      if (state == ACCESS && !l_we && !win) rdata0 <= mem_dout;
      if (state == ACCESS && !l_we && win) rdata1 <= mem_dout;
    end
endmodule
